// File: rtl/ysyx_22050133_rd_arbiter.sv
// Two-master (IFU = 0, LSU = 1) round-robin read arbiter onto a single downstream
// AR/R port. One outstanding single-beat transaction at a time; arbitration costs one cycle.
module ysyx_22050133_rd_arbiter #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      ifu_ar_valid_i,
    output logic                      ifu_ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] ifu_ar_addr_i,
    output logic                      ifu_r_valid_o,
    input  logic                      ifu_r_ready_i,
    output logic [AXI_DATA_WIDTH-1:0] ifu_r_data_o,

    input  logic                      lsu_ar_valid_i,
    output logic                      lsu_ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] lsu_ar_addr_i,
    output logic                      lsu_r_valid_o,
    input  logic                      lsu_r_ready_i,
    output logic [AXI_DATA_WIDTH-1:0] lsu_r_data_o,

    output logic                      s_ar_valid_o,
    input  logic                      s_ar_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0] s_ar_addr_o,
    input  logic                      s_r_valid_i,
    output logic                      s_r_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] s_r_data_i,

    output logic                      grant_o,
    output logic                      busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic   grant_reg, grant_next;
    logic   last_reg,  last_next;

    // Per-master views, indexed by master number, so the grant can select directly.
    logic [1:0]                m_ar_valid;
    logic [1:0]                m_r_ready;
    logic [1:0]                m_ar_ready;
    logic [1:0]                m_r_valid;
    logic [AXI_ADDR_WIDTH-1:0] m_ar_addr [2];

    logic in_ar;
    logic in_r;
    logic sel_ar_valid;
    logic sel_r_ready;

    assign m_ar_valid   = {lsu_ar_valid_i, ifu_ar_valid_i};
    assign m_r_ready    = {lsu_r_ready_i,  ifu_r_ready_i};
    assign m_ar_addr[0] = ifu_ar_addr_i;
    assign m_ar_addr[1] = lsu_ar_addr_i;

    assign in_ar        = (state_reg == AR);
    assign in_r         = (state_reg == R);
    assign sel_ar_valid = m_ar_valid[grant_reg];
    assign sel_r_ready  = m_r_ready[grant_reg];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign m_ar_ready[gi] = in_ar && (grant_reg == 1'(gi)) && s_ar_ready_i;
            assign m_r_valid[gi]  = in_r  && (grant_reg == 1'(gi)) && s_r_valid_i;
        end
    endgenerate

    assign ifu_ar_ready_o = m_ar_ready[0];
    assign lsu_ar_ready_o = m_ar_ready[1];
    assign ifu_r_valid_o  = m_r_valid[0];
    assign lsu_r_valid_o  = m_r_valid[1];
    assign ifu_r_data_o   = s_r_data_i;
    assign lsu_r_data_o   = s_r_data_i;

    // Address is passed through, never latched: masters hold it until ar_ready.
    assign s_ar_valid_o = in_ar && sel_ar_valid;
    assign s_ar_addr_o  = m_ar_addr[grant_reg];
    assign s_r_ready_o  = in_r && sel_r_ready;

    assign grant_o = grant_reg;
    assign busy_o  = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= 1'b0;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (|m_ar_valid) begin
                    // On a tie the master not served last wins.
                    grant_next = (&m_ar_valid) ? ~last_reg : m_ar_valid[1];
                    state_next = AR;
                end
            end
            AR: begin
                if (s_ar_valid_o && s_ar_ready_i) begin
                    state_next = R;
                end
            end
            R: begin
                if (s_r_valid_i && s_r_ready_o) begin
                    last_next  = grant_reg;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_22050133_rd_arbiter.sv
// Randomized bench for the read arbiter: transaction-level masters/slave plus a
// cycle reference model of the arbitration rules and a data scoreboard per master.
module tb_ysyx_22050133_rd_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]    ar_valid;
    logic [1:0]    r_ready;
    logic [AW-1:0] ar_addr [2];
    logic          s_ar_ready;
    logic          s_r_valid;
    logic [DW-1:0] s_r_data;

    logic          ifu_ar_ready, lsu_ar_ready, ifu_r_valid, lsu_r_valid;
    logic [DW-1:0] ifu_r_data, lsu_r_data;
    logic          s_ar_valid, s_r_ready, grant, busy;
    logic [AW-1:0] s_ar_addr;

    ysyx_22050133_rd_arbiter #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .ifu_ar_valid_i(ar_valid[0]), .ifu_ar_ready_o(ifu_ar_ready), .ifu_ar_addr_i(ar_addr[0]),
        .ifu_r_valid_o(ifu_r_valid), .ifu_r_ready_i(r_ready[0]), .ifu_r_data_o(ifu_r_data),
        .lsu_ar_valid_i(ar_valid[1]), .lsu_ar_ready_o(lsu_ar_ready), .lsu_ar_addr_i(ar_addr[1]),
        .lsu_r_valid_o(lsu_r_valid), .lsu_r_ready_i(r_ready[1]), .lsu_r_data_o(lsu_r_data),
        .s_ar_valid_o(s_ar_valid), .s_ar_ready_i(s_ar_ready), .s_ar_addr_o(s_ar_addr),
        .s_r_valid_i(s_r_valid), .s_r_ready_o(s_r_ready), .s_r_data_i(s_r_data),
        .grant_o(grant), .busy_o(busy)
    );

    logic [1:0]    dut_ar_ready, dut_r_valid;
    logic [DW-1:0] dut_r_data [2];
    assign dut_ar_ready  = {lsu_ar_ready, ifu_ar_ready};
    assign dut_r_valid   = {lsu_r_valid, ifu_r_valid};
    assign dut_r_data[0] = ifu_r_data;
    assign dut_r_data[1] = lsu_r_data;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = address, 2 = data.
    int phase = 0;
    int owner = 0;
    int last  = 1;

    // Traffic generators
    bit            pend [2];
    logic [AW-1:0] req_addr [2];
    logic [DW-1:0] exp_q [2][$];
    int            n_done [2];
    int            gseq [$];
    int            p_req [2];
    int            p_rrdy, p_sar, p_srv;
    bit            s_pend;
    logic [AW-1:0] s_addr;

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return {a ^ 32'h5A5A_0F0F, a};
    endfunction

    task automatic drive();
        for (int m = 0; m < 2; m++) begin
            if (!pend[m] && $urandom_range(99) < p_req[m]) begin
                pend[m]     = 1'b1;
                req_addr[m] = $urandom;
            end
            ar_valid[m] = pend[m];
            ar_addr[m]  = pend[m] ? req_addr[m] : $urandom;
            r_ready[m]  = ($urandom_range(99) < p_rrdy);
        end
        s_ar_ready = ($urandom_range(99) < p_sar);
        if (s_pend) begin
            s_r_valid = ($urandom_range(99) < p_srv);
            s_r_data  = mem_data(s_addr);
        end else begin
            s_r_valid = 1'($urandom);
            s_r_data  = {$urandom, $urandom};
        end
    endtask

    // Check mid-cycle, then advance the model at the clock edge.
    task automatic cycle();
        bit exp_sarv, ar_hs, r_hs;
        logic [DW-1:0] exp_d;
        #4;
        exp_sarv = (phase == 1) && ar_valid[owner];
        ar_hs    = exp_sarv && s_ar_ready;
        r_hs     = (phase == 2) && s_r_valid && r_ready[owner];
        check("busy", 64'(busy), 64'(phase != 0));
        check("grant", 64'(grant), 64'(owner));
        check("s_ar_valid", 64'(s_ar_valid), 64'(exp_sarv));
        check("s_r_ready", 64'(s_r_ready), 64'((phase == 2) && r_ready[owner]));
        for (int m = 0; m < 2; m++) begin
            check("ar_ready", 64'(dut_ar_ready[m]), 64'((phase == 1) && (m == owner) && s_ar_ready));
            check("r_valid", 64'(dut_r_valid[m]), 64'((phase == 2) && (m == owner) && s_r_valid));
        end
        if (exp_sarv) check("s_ar_addr", 64'(s_ar_addr), 64'(ar_addr[owner]));
        if (r_hs) begin
            if (exp_q[owner].size() == 0) begin
                check("rdata_q_empty", 64'(exp_q[owner].size()), 64'd1);
            end else begin
                exp_d = exp_q[owner].pop_front();
                check("r_data", dut_r_data[owner], exp_d);
            end
            n_done[owner]++;
            gseq.push_back(owner);
        end
        @(posedge clk);
        if (rst) begin
            phase = 0; owner = 0; last = 1; s_pend = 0;
            for (int m = 0; m < 2; m++) begin
                pend[m] = 0;
                exp_q[m].delete();
            end
        end else begin
            case (phase)
                0: if (ar_valid != 2'b00) begin
                    owner = (ar_valid == 2'b11) ? 1 - last : int'(ar_valid[1]);
                    phase = 1;
                end
                1: if (ar_hs) begin
                    phase       = 2;
                    pend[owner] = 0;
                    s_pend      = 1;
                    s_addr      = s_ar_addr;   // slave latches what it sees
                    exp_q[owner].push_back(mem_data(ar_addr[owner]));
                end
                2: if (r_hs) begin
                    last   = owner;
                    phase  = 0;
                    s_pend = 0;
                end
                default: phase = 0;
            endcase
        end
        #1;
    endtask

    task automatic set_probs(input int pi, input int pl, input int prr, input int psar, input int psrv);
        p_req[0] = pi; p_req[1] = pl; p_rrdy = prr; p_sar = psar; p_srv = psrv;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            cycle();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        gseq.delete();
        n_done[0] = 0;
        n_done[1] = 0;
    endtask

    initial begin
        int seq_code;
        bit hit;
        rst = 1'b1;
        set_probs(0, 0, 0, 0, 0);
        drive();
        @(posedge clk);
        #1;
        do_reset();

        // IFU alone, zero-wait slave and master
        set_probs(100, 0, 100, 100, 100);
        run(9);
        check("ifu_alone_done", 64'(n_done[0]), 64'd3);
        check("ifu_alone_lsu", 64'(n_done[1]), 64'd0);

        // Continuous contention: alternating grants, 3 cycles per transaction
        do_reset();
        set_probs(100, 100, 100, 100, 100);
        run(12);
        seq_code = 0;
        foreach (gseq[i]) seq_code = seq_code * 10 + gseq[i] + 1;
        check("rr_count", 64'(gseq.size()), 64'd4);
        check("rr_seq", 64'(seq_code), 64'd1212);

        // Random traffic: moderate, then slow slave / sluggish masters
        set_probs(30, 30, 60, 60, 60);
        run(2000);
        set_probs(80, 80, 25, 20, 25);
        run(1500);

        // Reset while in the data phase
        set_probs(100, 100, 0, 100, 0);
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            run(1);
            hit = (phase == 2);
        end
        check("reach_R", 64'(hit), 64'd1);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        set_probs(100, 100, 100, 100, 100);
        run(2);
        check("post_rst_grant", 64'(grant), 64'd0);
        check("post_rst_busy", 64'(busy), 64'd1);
        run(10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ysyx_22050133_rd_arbiter.md
Name: ysyx_22050133_rd_arbiter

Overview:
- Two-master, one-slave read arbiter on the team's simplified AXI subset: AR and R channels only, single beat, no id/len/resp.
- Shares one downstream read port (memory/CLINT interconnect) between IFU (master 0) and LSU (master 1).
- Round-robin on contention; one outstanding transaction at a time.
- LSU writes bypass this block.

Parameters:
- AXI_DATA_WIDTH, 64, read data width.
- AXI_ADDR_WIDTH, 32, address width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- ifu_ar_valid_i  input  1  IFU read request
- ifu_ar_ready_o  output  1  IFU address accepted
- ifu_ar_addr_i  input  AXI_ADDR_WIDTH  IFU read address
- ifu_r_valid_o  output  1  IFU data valid
- ifu_r_ready_i  input  1  IFU ready for data
- ifu_r_data_o  output  AXI_DATA_WIDTH  IFU read data
- lsu_ar_valid_i  input  1  LSU read request
- lsu_ar_ready_o  output  1  LSU address accepted
- lsu_ar_addr_i  input  AXI_ADDR_WIDTH  LSU read address
- lsu_r_valid_o  output  1  LSU data valid
- lsu_r_ready_i  input  1  LSU ready for data
- lsu_r_data_o  output  AXI_DATA_WIDTH  LSU read data
- s_ar_valid_o  output  1  downstream request
- s_ar_ready_i  input  1  downstream address accepted
- s_ar_addr_o  output  AXI_ADDR_WIDTH  downstream address
- s_r_valid_i  input  1  downstream data valid
- s_r_ready_o  output  1  downstream data ready
- s_r_data_i  input  AXI_DATA_WIDTH  downstream data
- grant_o  output  1  current owner (0 = IFU, 1 = LSU)
- busy_o  output  1  transaction in progress (state != IDLE)

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Registers:
  - state: IDLE / AR / R
  - grant: 1 bit
  - last: 1 bit, the last master served
- Reset:
  - state = IDLE, grant = 0, last = 1, so IFU wins the first tie.
  - All valid/ready outputs are 0; s_ar_addr_o and the r_data outputs are don't-care.
- IDLE:
  - No valid request: stay in IDLE.
  - Exactly one ar_valid: grant <= that master.
  - Both ar_valid: grant <= ~last.
  - On any request, go to AR the next cycle. Arbitration costs exactly 1 cycle.
  - All handshake outputs are 0 in IDLE.
- AR:
  - s_ar_valid_o = granted master's ar_valid.
  - s_ar_addr_o = granted master's addr.
  - Granted master's ar_ready = s_ar_ready_i; the other master's ar_ready = 0.
  - On s_ar_valid_o & s_ar_ready_i, go to R.
  - If the granted master drops ar_valid (protocol violation), stay in AR with s_ar_valid_o = 0.
- R:
  - Granted master's r_valid = s_r_valid_i; the other master's r_valid = 0.
  - s_r_ready_o = granted master's r_ready.
  - s_r_data_i drives both r_data outputs; only the granted master sees valid.
  - On s_r_valid_i & s_r_ready_o: last <= grant, state <= IDLE.
- All channel outputs are combinational from registered state/grant. No extra latency is added beyond the IDLE arbitration cycle.
- Minimum back-to-back cost: 3 cycles per transaction (IDLE + AR + R), with zero-wait slave and master.
- The grant is frozen from IDLE exit until the R handshake. A request from the other master arriving mid-transaction waits with ar_ready = 0.
- Round-robin guarantees fairness: with both masters continuously requesting, grants alternate, and no master waits more than one full transaction.
- Masters must hold ar_valid and addr stable until their ar_ready. The arbiter does not latch the address.
- Reset mid-operation (AR or R): the next cycle is IDLE, last = 1, and all outputs are 0. The downstream slave shares rst and likewise abandons the transaction. No beat is delivered after reset.
- s_r_valid_i while in IDLE/AR is ignored; s_r_ready_o = 0 then.

Test Plan:
1. IFU alone reads 0x8000_0000; slave ar_ready=1, returns r_data=0x1122334455667788 the cycle after AR handshake → ifu_r_valid_o=1 with that data; lsu_r_valid_o=0; grant_o=0; busy_o low again 1 cycle after R handshake.
2. After reset, IFU and LSU assert ar_valid in the same cycle (0x8000_0000, 0x0200_BFF8) → IFU served first, then LSU; s_ar_addr_o sequence 0x8000_0000 then 0x0200_BFF8.
3. Both request continuously for 4 transactions → grant_o sequence 0,1,0,1; 12 cycles total with zero-wait slave.
4. Slave holds s_ar_ready_i low 3 cycles, IFU holds r_ready low 2 cycles → state stays AR/R accordingly; s_ar_valid_o and s_ar_addr_o stable; exactly one r handshake.
5. LSU asserts ar_valid while IFU is in R → lsu_ar_ready_o=0 until IFU's R handshake; LSU is granted in the following IDLE cycle.
6. rst asserted for 1 cycle in R state → next cycle busy_o=0 and all valid/ready outputs 0; a subsequent simultaneous request grants IFU.
